// File: rtl/spi_io_bridge_pkg.sv
// Shared definitions for spi_io_bridge: register map, STATUS/CTRL bit positions,
// FSM state encoding and the DIV reset default.
package spi_io_bridge_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_OVR     = 2;
  localparam int CTRL_SSEN  = 0;
  localparam int CTRL_IRQEN = 7;

  localparam logic [7:0] DIV_RST_DEF = 8'd12;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } spi_state_t;

endpackage

// File: rtl/spi_io_bridge_strobe_sync.sv
// Two-flop synchronizer for an asynchronous host strobe, with one-cycle
// rise and fall pulses. Flops reset high because the strobes idle high.
module strobe_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= strobe;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/spi_io_bridge.sv
// PC Card I/O window bridging host IOWR/IORD cycles to a mode-0 SPI master.
// Optional SPI_IRQ_EN adds the CTRL.IRQEN bit and the INT completion interrupt.
//
// state   | meaning
// S_IDLE  | no transfer, SCLK and MOSI low
// S_LEAD  | MOSI holds bit7 for one half-period before the first SCLK rise
// S_SHIFT | SCLK toggles each half-period, 8 bits plus a trailing low half-period
// S_DONE  | one cycle: latch received byte, set DONE, drop BUSY
module spi_io_bridge
  import spi_io_bridge_pkg::*;
#(
  parameter logic [7:0] DIV_RST = DIV_RST_DEF
) (
  input  logic        clk_26,
  input  logic        RESETB,
  input  logic [15:0] A,
  input  logic [7:0]  D_in,
  output logic [7:0]  D_out,
  input  logic        IOWR,
  input  logic        IORD,
  input  logic        CE1,
  output logic        DDIR,
  output logic        INPACK,
  output logic        SS,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO,
  output logic        INT
);

  spi_state_t state;
  logic [7:0] div, div_lat, cnt, sh, rx, rd_mux;
  logic [2:0] bit_cnt;
  logic       busy, done, ovr, ssen, irqen;
  logic       sclk_q, mosi_q, rd_pend;
  logic       hit, wr_fall, rd_rise, rd_fall, unused_wr_rise;

  strobe_sync u_wr_sync (.clk(clk_26), .rst_n(RESETB), .strobe(IOWR), .rise(unused_wr_rise), .fall(wr_fall));
  strobe_sync u_rd_sync (.clk(clk_26), .rst_n(RESETB), .strobe(IORD), .rise(rd_rise), .fall(rd_fall));

  assign hit    = !CE1 && (A[15:2] == 14'd0);
  assign DDIR   = hit && !IORD;
  assign INPACK = !DDIR;

  always_comb begin
    rd_mux = 8'h00;
    case (A[1:0])
      REG_DATA: rd_mux = rx;
      REG_STATUS: begin
        rd_mux[ST_BUSY] = busy;
        rd_mux[ST_DONE] = done;
        rd_mux[ST_OVR]  = ovr;
      end
      REG_CTRL: begin
        rd_mux[CTRL_SSEN]  = ssen;
        rd_mux[CTRL_IRQEN] = irqen;
      end
      default: rd_mux = div;
    endcase
  end

  assign D_out = DDIR ? rd_mux : 8'h00;
  assign SS    = !ssen;
  assign SCLK  = sclk_q;
  assign MOSI  = mosi_q;

`ifdef SPI_IRQ_EN
  always_ff @(posedge clk_26 or negedge RESETB) begin
    if (!RESETB) irqen <= 1'b0;
    else if (wr_fall && hit && (A[1:0] == REG_CTRL)) irqen <= D_in[CTRL_IRQEN];
  end
  assign INT = !(done && irqen);
`else
  assign irqen = 1'b0;
  assign INT   = 1'b1;
`endif

  always_ff @(posedge clk_26 or negedge RESETB) begin
    if (!RESETB) begin
      state   <= S_IDLE;
      div     <= DIV_RST;
      div_lat <= 8'h00;
      cnt     <= 8'h00;
      sh      <= 8'h00;
      rx      <= 8'h00;
      bit_cnt <= 3'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovr     <= 1'b0;
      ssen    <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      rd_pend <= 1'b0;
    end else begin
      // The address can move before the strobe ends, so remember at the start
      // of the read whether it targets DATA.
      if (rd_fall) rd_pend <= hit && (A[1:0] == REG_DATA);
      if (rd_rise && rd_pend) done <= 1'b0;

      case (state)
        S_IDLE: begin
          sclk_q <= 1'b0;
          mosi_q <= 1'b0;
        end
        S_LEAD: begin
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
          else begin
            cnt    <= div_lat;
            sclk_q <= 1'b1;
            sh     <= {sh[6:0], MISO};
            state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
          else begin
            cnt <= div_lat;
            if (sclk_q) begin
              sclk_q  <= 1'b0;
              mosi_q  <= (bit_cnt == 3'd7) ? 1'b0 : sh[7];
              bit_cnt <= bit_cnt + 3'd1;
            end else if (bit_cnt == 3'd0) begin
              state <= S_DONE;
            end else begin
              sclk_q <= 1'b1;
              sh     <= {sh[6:0], MISO};
            end
          end
        end
        S_DONE: begin
          rx    <= sh;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (wr_fall && hit) begin
        case (A[1:0])
          REG_DATA: begin
            if (busy) ovr <= 1'b1;
            else begin
              sh      <= D_in;
              div_lat <= div;
              cnt     <= div;
              bit_cnt <= 3'd0;
              busy    <= 1'b1;
              mosi_q  <= D_in[7];
              state   <= S_LEAD;
            end
          end
          REG_STATUS: if (D_in[ST_OVR]) ovr <= 1'b0;
          REG_CTRL:   ssen <= D_in[CTRL_SSEN];
          default:    div <= D_in;
        endcase
      end
    end
  end

endmodule
